// File: rtl/out_display.sv
// out_display: SAP-1 output register with double-dabble BCD conversion and 4-digit multiplexed seven-segment scan
module out_display #(
  parameter int DIV_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] bus,
  output logic [7:0] value,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an
);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [7:0]           sr_q, sr_d;
  logic [11:0]          bcd_q, bcd_d, adj;
  logic [7:0]           value_q, value_d;
  logic [3:0]           hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [1:0]           sel;
  logic [3:0]           digit;
  logic                 blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // add-3 correction on every BCD nibble that has reached 5, ahead of the shift
  always_comb begin
    adj[3:0]  = (bcd_q[3:0]  >= 4'd5) ? bcd_q[3:0]  + 4'd3 : bcd_q[3:0];
    adj[7:4]  = (bcd_q[7:4]  >= 4'd5) ? bcd_q[7:4]  + 4'd3 : bcd_q[7:4];
    adj[11:8] = (bcd_q[11:8] >= 4'd5) ? bcd_q[11:8] + 4'd3 : bcd_q[11:8];
  end

  // conversion FSM next state; a load restarts the conversion from any state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    bcd_d   = bcd_q;
    value_d = value_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    div_d   = div_q + 1'b1;
    if (load) begin
      value_d = bus;
      sr_d    = bus;
      bcd_d   = '0;
      cnt_d   = '0;
      state_d = SHIFT;
    end else begin
      case (state_q)
        SHIFT: begin
          {bcd_d, sr_d} = {adj[10:0], sr_q, 1'b0};
          cnt_d         = cnt_q + 3'd1;
          state_d       = (cnt_q == 3'd7) ? COMMIT : SHIFT;
        end
        COMMIT: begin
          hund_d  = bcd_q[11:8];
          tens_d  = bcd_q[7:4];
          ones_d  = bcd_q[3:0];
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state and display registers; reset discards any conversion in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      bcd_q   <= '0;
      value_q <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bcd_q   <= bcd_d;
      value_q <= value_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      div_q   <= div_d;
    end
  end

  // digit scan with leading-zero blanking; position 3 is never lit
  always_comb begin
    sel   = div_q[DIV_WIDTH-1 -: 2];
    an    = ~(4'b0001 << sel);
    digit = (sel == 2'd0) ? ones_q : (sel == 2'd1) ? tens_q : hund_q;
    blank = (sel == 2'd3) || (sel == 2'd2 && hund_q == 4'd0) ||
            (sel == 2'd1 && hund_q == 4'd0 && tens_q == 4'd0);
    seg   = blank ? 7'h7F : seg7(digit);
  end

  assign value = value_q;
  assign busy  = (state_q != IDLE);
endmodule
